// File: rtl/mem_stage_dmem_ctrl.sv
// rtl/mem_stage_dmem_ctrl.sv - MEM-stage data-memory request/response controller with lane alignment
`timescale 1ns/1ps
module mem_stage_dmem_ctrl #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_read_o,
    output logic        dmem_write_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_mbe_o,
    input  logic        dmem_resp_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // access width encoding
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    logic [1:0]  state_q;
    logic        read_q, write_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mbe_q;
    logic [1:0]  off_q, width_q;
    logic        uns_q, is_load_q;
    logic [31:0] load_data_q;
    logic [31:0] wait_cnt_q;
    logic        timeout_q;

    logic        is_store, op, misaligned, accept;
    logic [1:0]  off, width;
    logic [3:0]  mbe_n;
    logic [31:0] wdata_n, rshift, load_ext;

    // Decode the incoming op: width, alignment, lane placement. A store wins over a load.
    always_comb begin
        is_store = mem_write_i;
        op       = mem_read_i | mem_write_i;
        off      = addr_i[1:0];
        case (funct3_i)
            3'd0:    width = W_BYTE;
            3'd1:    width = W_HALF;
            3'd4:    width = is_store ? W_WORD : W_BYTE;
            3'd5:    width = is_store ? W_WORD : W_HALF;
            default: width = W_WORD;
        endcase
        misaligned = ((width == W_HALF) && off[0]) || ((width == W_WORD) && (off != 2'b00));
        mbe_n   = 4'b0000;
        wdata_n = 32'd0;
        if (is_store) begin
            case (width)
                W_BYTE: begin
                    mbe_n   = 4'b0001 << off;
                    wdata_n = {24'd0, wdata_i[7:0]} << {off, 3'b000};
                end
                W_HALF: begin
                    mbe_n   = 4'b0011 << off;
                    wdata_n = {16'd0, wdata_i[15:0]} << {off, 3'b000};
                end
                default: begin
                    mbe_n   = 4'hF;
                    wdata_n = wdata_i;
                end
            endcase
        end
        accept = (state_q == S_IDLE) && op && !misaligned;
    end

    // Shift the returned word down to the addressed byte and extend to 32 bits.
    always_comb begin
        rshift = dmem_rdata_i >> {off_q, 3'b000};
        case (width_q)
            W_BYTE:  load_ext = {{24{rshift[7] & ~uns_q}}, rshift[7:0]};
            W_HALF:  load_ext = {{16{rshift[15] & ~uns_q}}, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

    // Request FSM: latch the op in IDLE, hold the request in BUSY, release the pipeline in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mbe_q       <= 4'd0;
            off_q       <= 2'd0;
            width_q     <= 2'd0;
            uns_q       <= 1'b0;
            is_load_q   <= 1'b0;
            load_data_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q    <= S_BUSY;
                        read_q     <= ~is_store;
                        write_q    <= is_store;
                        addr_q     <= {addr_i[31:2], 2'b00};
                        wdata_q    <= wdata_n;
                        mbe_q      <= mbe_n;
                        off_q      <= off;
                        width_q    <= width;
                        uns_q      <= funct3_i[2];
                        is_load_q  <= ~is_store;
                        wait_cnt_q <= 32'd0;
                    end
                end
                S_BUSY: begin
                    if (dmem_resp_i) begin
                        state_q <= S_DONE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        addr_q  <= 32'd0;
                        wdata_q <= 32'd0;
                        mbe_q   <= 4'd0;
                        if (is_load_q) begin
                            load_data_q <= load_ext;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                        if ((WAIT_LIMIT != 0) && (wait_cnt_q == WAIT_LIMIT - 1)) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Input-dependent flags are gated by reset so every output reads 0 while rst is low.
    always_comb begin
        stall_o      = rst & ((state_q == S_BUSY) | accept);
        misalign_o   = rst & (state_q == S_IDLE) & op & misaligned;
        load_valid_o = (state_q == S_DONE) & is_load_q;
        dmem_read_o  = read_q;
        dmem_write_o = write_q;
        dmem_addr_o  = addr_q;
        dmem_wdata_o = wdata_q;
        dmem_mbe_o   = mbe_q;
        load_data_o  = load_data_q;
        timeout_o    = timeout_q;
    end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// tb/tb_mem_stage_dmem_ctrl.sv - table-driven bench for mem_stage_dmem_ctrl
`timescale 1ns/1ps
module tb_mem_stage_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_read_o, dmem_write_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_mbe_o;
    logic        dmem_resp_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o, misalign_o, timeout_o;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] last_ld = 32'd0;

    always #5 clk = ~clk;

    mem_stage_dmem_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_mbe_o(dmem_mbe_o),
        .dmem_resp_i(dmem_resp_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          waits;
        logic        e_mis, e_rd, e_wr;
        logic [3:0]  e_mbe;
        logic [31:0] e_addr, e_wdata, e_ld;
        logic        e_lv;
        int          e_stall;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, int waits, logic e_mis,
                                logic e_rd, logic e_wr, logic [3:0] e_mbe, logic [31:0] e_addr,
                                logic [31:0] e_wdata, logic [31:0] e_ld, logic e_lv, int e_stall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.e_mis = e_mis; v.e_rd = e_rd; v.e_wr = e_wr; v.e_mbe = e_mbe;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_ld = e_ld; v.e_lv = e_lv; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0;
        addr_i = 32'd0; wdata_i = 32'd0; dmem_resp_i = 1'b0; dmem_rdata_i = 32'd0;
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns on a falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        int  c;
        int  stalls;
        bit  done;
        mem_read_i = v.rd; mem_write_i = v.wr; funct3_i = v.f3;
        addr_i = v.addr; wdata_i = v.wdata; dmem_resp_i = 1'b0; dmem_rdata_i = v.rdata;
        @(negedge clk);
        if (v.e_mis) begin
            chk($sformatf("v%0d misalign", idx), {31'd0, misalign_o}, 32'd1);
            chk($sformatf("v%0d mis_stall", idx), {31'd0, stall_o}, 32'd0);
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            chk($sformatf("v%0d mis_noreq", idx), {30'd0, dmem_read_o, dmem_write_o}, 32'd0);
            chk($sformatf("v%0d mis_pulse_end", idx), {31'd0, misalign_o}, 32'd0);
            return;
        end
        chk($sformatf("v%0d no_misalign", idx), {31'd0, misalign_o}, 32'd0);
        stalls = stall_o ? 1 : 0;
        c = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            @(posedge clk); #1;
            c++;
            dmem_resp_i = (c == v.waits + 1);
            @(negedge clk);
            if (stall_o) stalls++;
            else done = 1'b1;
            if (c == 1) begin
                chk($sformatf("v%0d rd", idx), {31'd0, dmem_read_o}, {31'd0, v.e_rd});
                chk($sformatf("v%0d wr", idx), {31'd0, dmem_write_o}, {31'd0, v.e_wr});
                chk($sformatf("v%0d addr", idx), dmem_addr_o, v.e_addr);
                chk($sformatf("v%0d wdata", idx), dmem_wdata_o, v.e_wdata);
                chk($sformatf("v%0d mbe", idx), {28'd0, dmem_mbe_o}, {28'd0, v.e_mbe});
            end
        end
        chk($sformatf("v%0d done_seen", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d stall_cycles", idx), stalls, v.e_stall);
        chk($sformatf("v%0d load_valid", idx), {31'd0, load_valid_o}, {31'd0, v.e_lv});
        chk($sformatf("v%0d req_dropped", idx), {30'd0, dmem_read_o, dmem_write_o}, 32'd0);
        if (v.e_lv) begin
            last_ld = v.e_ld;
            chk($sformatf("v%0d load_data", idx), load_data_o, v.e_ld);
        end
        chk($sformatf("v%0d timeout", idx), {31'd0, timeout_o}, 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk($sformatf("v%0d lv_end", idx), {31'd0, load_valid_o}, 32'd0);
        chk($sformatf("v%0d ld_hold", idx), load_data_o, last_ld);
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2);
        vecs[1]  = mk(0, 1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 0, 0, 1, 4'h8, 32'h100, 32'hA5000000, 32'h0, 0, 2);
        vecs[2]  = mk(1, 0, 3'd0, 32'h202, 32'h0, 32'h12807F34, 3, 0, 1, 0, 4'h0, 32'h200, 32'h0, 32'hFFFFFF80, 1, 5);
        vecs[3]  = mk(1, 0, 3'd4, 32'h202, 32'h0, 32'h12807F34, 3, 0, 1, 0, 4'h0, 32'h200, 32'h0, 32'h00000080, 1, 5);
        vecs[4]  = mk(1, 0, 3'd1, 32'h201, 32'h0, 32'h0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        vecs[5]  = mk(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 1, 0, 0, 1, 4'hC, 32'h100, 32'hABCD0000, 32'h0, 0, 3);
        vecs[6]  = mk(1, 0, 3'd1, 32'h202, 32'h0, 32'h80017FFF, 0, 0, 1, 0, 4'h0, 32'h200, 32'h0, 32'hFFFF8001, 1, 2);
        vecs[7]  = mk(1, 0, 3'd5, 32'h200, 32'h0, 32'h8001F00F, 0, 0, 1, 0, 4'h0, 32'h200, 32'h0, 32'h0000F00F, 1, 2);
        vecs[8]  = mk(1, 0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 2, 0, 1, 0, 4'h0, 32'h300, 32'h0, 32'hCAFEF00D, 1, 4);
        vecs[9]  = mk(0, 1, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        vecs[10] = mk(1, 1, 3'd2, 32'h104, 32'h11223344, 32'h0, 0, 0, 0, 1, 4'hF, 32'h104, 32'h11223344, 32'h0, 0, 2);
        vecs[11] = mk(1, 0, 3'd0, 32'h201, 32'h0, 32'h00007F00, 1, 0, 1, 0, 4'h0, 32'h200, 32'h0, 32'h0000007F, 1, 3);
        vecs[12] = mk(0, 1, 3'd5, 32'h108, 32'h55667788, 32'h0, 0, 0, 0, 1, 4'hF, 32'h108, 32'h55667788, 32'h0, 0, 2);
        vecs[13] = mk(1, 0, 3'd3, 32'h10C, 32'h0, 32'h89ABCDEF, 0, 0, 1, 0, 4'h0, 32'h10C, 32'h0, 32'h89ABCDEF, 1, 2);

        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk("rst_req", {30'd0, dmem_read_o, dmem_write_o}, 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_flags", {28'd0, stall_o, load_valid_o, misalign_o, timeout_o}, 32'd0);
        chk("rst_ld", load_data_o, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            run_vec(vecs[i], i);
        end

        // A response while IDLE must be ignored.
        @(posedge clk); #1;
        dmem_resp_i = 1'b1; dmem_rdata_i = 32'h5A5A5A5A;
        @(posedge clk); #1;
        dmem_resp_i = 1'b0;
        @(negedge clk);
        chk("idle_resp_lv", {31'd0, load_valid_o}, 32'd0);
        chk("idle_resp_ld", load_data_o, last_ld);
        chk("idle_resp_stall", {31'd0, stall_o}, 32'd0);

        // Timeout: response withheld for six BUSY cycles with WAIT_LIMIT=4.
        @(posedge clk); #1;
        mem_read_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h400; dmem_rdata_i = 32'h01020304;
        @(negedge clk);
        chk("to_c0", {31'd0, timeout_o}, 32'd0);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            dmem_resp_i = (c == 7);
            @(negedge clk);
            chk($sformatf("to_c%0d", c), {31'd0, timeout_o}, {31'd0, (c >= 5)});
            chk($sformatf("to_stall_c%0d", c), {31'd0, stall_o}, 32'd1);
        end
        @(posedge clk); #1;
        dmem_resp_i = 1'b0;
        @(negedge clk);
        chk("to_done_lv", {31'd0, load_valid_o}, 32'd1);
        chk("to_done_ld", load_data_o, 32'h01020304);
        chk("to_done_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("to_sticky", {31'd0, timeout_o}, 32'd1);

        // Reset in the middle of BUSY drops the request at once.
        @(posedge clk); #1;
        mem_read_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy_req", {31'd0, dmem_read_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_req", {30'd0, dmem_read_o, dmem_write_o}, 32'd0);
        chk("abort_addr", dmem_addr_o, 32'd0);
        chk("abort_flags", {28'd0, stall_o, load_valid_o, misalign_o, timeout_o}, 32'd0);
        chk("abort_ld", load_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        last_ld = 32'd0;
        @(posedge clk); #1;
        run_vec(vecs[0], 100);
        @(posedge clk); #1;
        run_vec(vecs[8], 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
